// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and small op-classification helpers used by the decoder, hazard unit and muldiv_unit.
package muldiv_unit_pkg;

  localparam int MD_XLEN     = 32;
  localparam int MD_CNT_W    = 5;
  localparam int MD_LAST_ITR = MD_XLEN - 1;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Fixed 34-cycle latency from accepted start to the md_done cycle.
//
// state   | meaning
// MD_IDLE | waiting for md_start; MTHI/MTLO writes accepted here
// MD_CALC | one shift-add / restoring shift-subtract step per cycle, 32 steps
// MD_FIX  | sign correction, HI/LO update, md_done raised for the next cycle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] md_op_x,
  input  logic [XLEN-1:0] md_op_y,
  input  logic            md_hi_we,
  input  logic            md_lo_we,
  input  logic [XLEN-1:0] md_wdata,
  output logic            md_busy,
  output logic            md_done,
  output logic            md_div_zero,
  output logic [XLEN-1:0] md_hi,
  output logic [XLEN-1:0] md_lo
);

  md_state_e             state_q, state_d;
  md_op_e                op_q, op_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  x_sign_q, x_sign_d;
  logic                  y_sign_q, y_sign_d;
  logic [XLEN-1:0]       acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]       acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       hi_q, hi_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  div_zero_q, div_zero_d;

  logic                  start_signed;
  logic [XLEN:0]         div_shift;
  logic                  div_ge;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     prod_mag;
  logic                  div_by_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_start) state_d = MD_CALC;
      MD_CALC: if (cnt_q == MD_CNT_W'(MD_LAST_ITR)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy     = (state_q != MD_IDLE);
    md_done     = done_q;
    md_div_zero = div_zero_q;
    md_hi       = hi_q;
    md_lo       = lo_q;
  end

  // Datapath: acc_lo holds |x| (multiplier / dividend-then-quotient), b holds |y|.
  always_comb begin
    op_d         = op_q;
    cnt_d        = cnt_q;
    x_sign_d     = x_sign_q;
    y_sign_d     = y_sign_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    div_zero_d   = 1'b0;
    start_signed = md_is_signed(md_op_e'(md_op));
    div_shift    = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_ge       = (div_shift >= {1'b0, b_q});
    mul_sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    prod_mag     = {acc_hi_q, acc_lo_q};
    div_by_zero  = (b_q == '0);

    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          op_d     = md_op_e'(md_op);
          x_sign_d = start_signed & md_op_x[XLEN-1];
          y_sign_d = start_signed & md_op_y[XLEN-1];
          acc_lo_d = (start_signed & md_op_x[XLEN-1]) ? -md_op_x : md_op_x;
          b_d      = (start_signed & md_op_y[XLEN-1]) ? -md_op_y : md_op_y;
          acc_hi_d = '0;
          cnt_d    = '0;
        end else begin
          if (md_hi_we) hi_d = md_wdata;
          if (md_lo_we) lo_d = md_wdata;
        end
      end
      MD_CALC: begin
        cnt_d = cnt_q + MD_CNT_W'(1);
        if (md_is_div(op_q)) begin
          acc_hi_d = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[XLEN:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
      end
      MD_FIX: begin
        done_d = 1'b1;
        if (md_is_div(op_q)) begin
          // A zero divisor leaves |x| as remainder, so the signed fix restores the original dividend.
          div_zero_d = div_by_zero;
          hi_d       = x_sign_q ? -acc_hi_q : acc_hi_q;
          lo_d       = div_by_zero ? '1 : ((x_sign_q ^ y_sign_q) ? -acc_lo_q : acc_lo_q);
        end else begin
          {hi_d, lo_d} = (x_sign_q ^ y_sign_q) ? -prod_mag : prod_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= MD_MULT;
      cnt_q      <= '0;
      x_sign_q   <= 1'b0;
      y_sign_q   <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      x_sign_q   <= x_sign_d;
      y_sign_q   <= y_sign_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic/latency model compared every cycle,
// plus directed vectors with literal expected HI/LO values.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_start = 1'b0;
  logic [1:0]  md_op = 2'd0;
  logic [31:0] md_op_x = '0;
  logic [31:0] md_op_y = '0;
  logic        md_hi_we = 1'b0;
  logic        md_lo_we = 1'b0;
  logic [31:0] md_wdata = '0;
  logic        md_busy;
  logic        md_done;
  logic        md_div_zero;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_op_x    (md_op_x),
    .md_op_y    (md_op_y),
    .md_hi_we   (md_hi_we),
    .md_lo_we   (md_lo_we),
    .md_wdata   (md_wdata),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_div_zero(md_div_zero),
    .md_hi      (md_hi),
    .md_lo      (md_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {div_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [64:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      OP_MULT: begin
        sq = sa * sb;
        r  = {1'b0, sq[63:0]};
      end
      OP_MULTU: begin
        up = ua * ub;
        r  = {1'b0, up[63:0]};
      end
      OP_DIV: begin
        if (b == 32'd0) r = {1'b1, a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {1'b0, sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {1'b1, a, 32'hFFFF_FFFF};
        else            r = {1'b0, a % b, a / b};
      end
    endcase
    return r;
  endfunction

  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [64:0] m_pend = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          {m_dz, m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (md_start) begin
        m_cnt  = 33;
        m_pend = model_op(md_op, md_op_x, md_op_y);
      end else begin
        if (md_hi_we) m_hi = md_wdata;
        if (md_lo_we) m_lo = md_wdata;
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", {63'd0, md_busy}, {63'd0, (m_cnt > 0)});
      chk("model_done", {63'd0, md_done}, {63'd0, m_done});
      chk("model_div_zero", {63'd0, md_div_zero}, {63'd0, m_dz});
      chk("model_hi", {32'd0, md_hi}, {32'd0, m_hi});
      chk("model_lo", {32'd0, md_lo}, {32'd0, m_lo});
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    md_op_x  = a;
    md_op_y  = b;
    @(negedge clk);
    md_start = 1'b0;
    md_op_x  = 32'hDEAD_BEEF;
    md_op_y  = 32'h0BAD_F00D;
  endtask

  // Called one cycle after the accepting edge with lat0 = cycles already elapsed.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (md_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (md_done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (md_done === 1'b1) n++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int lat;
    start_op(op, a, b);
    wait_done(1, lat);
    chk({name, "_latency"}, lat, 34);
    chk({name, "_hi"}, {32'd0, md_hi}, {32'd0, exp_hi});
    chk({name, "_lo"}, {32'd0, md_lo}, {32'd0, exp_lo});
    chk({name, "_dz"}, {63'd0, md_div_zero}, {63'd0, exp_dz});
  endtask

  initial begin
    int lat;
    int n;

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, md_busy}, 64'd0);
    chk("reset_done", {63'd0, md_done}, 64'd0);
    chk("reset_hi", {32'd0, md_hi}, 64'd0);
    chk("reset_lo", {32'd0, md_lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min_neg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);

    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("divu_zero_dz_pulse", {63'd0, md_div_zero}, 64'd0);
    chk("divu_zero_done_pulse", {63'd0, md_done}, 64'd0);
    run_op("div_neg8_zero", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);

    // Start-while-busy with an MTHI attempt mid-operation.
    @(negedge clk);
    start_op(OP_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    md_hi_we = 1'b1;
    md_wdata = 32'h1234;
    @(negedge clk);
    md_hi_we = 1'b0;
    repeat (4) @(negedge clk);
    start_op(OP_DIVU, 32'd9, 32'd3);
    wait_done(11, lat);
    chk("busy_start_latency", lat, 34);
    chk("busy_start_hi", {32'd0, md_hi}, 64'd0);
    chk("busy_start_lo", {32'd0, md_lo}, 64'd12);
    count_dones(40, n);
    chk("busy_start_single_done", n, 0);

    md_hi_we = 1'b1;
    md_wdata = 32'h1234;
    @(negedge clk);
    md_hi_we = 1'b0;
    chk("mthi_idle", {32'd0, md_hi}, 64'h1234);
    md_lo_we = 1'b1;
    md_wdata = 32'h5678;
    @(negedge clk);
    md_lo_we = 1'b0;
    chk("mtlo_idle", {32'd0, md_lo}, 64'h5678);

    // MTHI in the accepting cycle loses to the start.
    md_hi_we = 1'b1;
    md_wdata = 32'hAAAA_5555;
    start_op(OP_MULTU, 32'd6, 32'd7);
    md_hi_we = 1'b0;
    wait_done(1, lat);
    chk("start_wins_hi", {32'd0, md_hi}, 64'd0);
    chk("start_wins_lo", {32'd0, md_lo}, 64'd42);

    // Reset mid-operation.
    @(negedge clk);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, md_busy}, 64'd0);
    chk("rst_mid_hi", {32'd0, md_hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, md_lo}, 64'd0);
    count_dones(40, n);
    chk("rst_mid_no_done", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
